rv32i_multicycle_ctrl: RTL and testbench
========================================

Name: rv32i_multicycle_ctrl

Overview:
- Multi-cycle control FSM for the RV32I core subset: LOAD, OP-IMM, STORE, OP.
- Sequences fetch, decode, execute, memory and writeback over a single shared memory port.
- Drives the write enables for IR, PC and the register file, plus the ALU and writeback muxes.
- Takes opcode/funct3/rd fields from the instruction decoder and handshakes with memory via req/ready.

Parameters:
- MEM_TIMEOUT, 15: maximum wait cycles for mem_ready per access before trapping.
- TO_W, 4: width of the timeout counter; must hold MEM_TIMEOUT.
- CNT_W, 32: width of the performance counters (optional feature only).

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- en  in  1  run enable; sampled in IDLE and at instruction retire.
- opcode  in  7  instruction[6:0] from the decoder.
- funct3  in  3  instruction[14:12].
- rd_zero  in  1  rd == x0.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req  out  1  memory access request.
- mem_we  out  1  1 = store, 0 = read.
- addr_sel  out  1  0 = PC, 1 = ALU result.
- ir_we  out  1  load IR with the read data.
- alu_en  out  1  ALU result register enable.
- alu_src_imm  out  1  ALU operand B: 1 = immediate, 0 = rs2.
- wb_sel  out  1  0 = ALU, 1 = memory data.
- rf_we  out  1  register file write.
- pc_we  out  1  PC <= PC+4.
- trap  out  1  sticky fault flag.
- trap_cause  out  2  01 = illegal, 10 = memory timeout.
- busy  out  1  state != IDLE and state != TRAP.

Behaviour:
- Reset (async, any state, mid-access included): state = IDLE, timeout counter = 0, class register = 0, trap = 0, trap_cause = 00. All strobes are 0 while rst is high.
- Outputs are decoded from the registered state. ir_we and the completion pc_we also qualify on mem_ready (Mealy).
- IDLE: all strobes 0. en = 1 -> FETCH.
- FETCH: mem_req = 1, mem_we = 0, addr_sel = 0.
  - mem_ready = 1: ir_we = 1, go to DECODE.
  - Each non-ready cycle increments the counter. If the counter reaches MEM_TIMEOUT without ready: TRAP with cause 10, mem_req drops next cycle.
  - Zero-wait memory (ready in the request cycle) costs one cycle.
- DECODE: classify opcode; the class is latched here.
  - Legal encodings:
    - LOAD 0000011: funct3 in {000,001,010,100,101}.
    - OP-IMM 0010011: any funct3.
    - STORE 0100011: funct3 in {000,001,010}.
    - OP 0110011: any funct3.
  - Any other opcode, or an illegal funct3, goes to TRAP with cause 01.
  - Legal encodings go to EXEC.
- EXEC: alu_en = 1, alu_src_imm = 1 for LOAD/OP-IMM/STORE. LOAD/STORE -> MEM; OP/OP-IMM -> WB.
- MEM: mem_req = 1, addr_sel = 1, mem_we = (class == STORE); same timeout rule as FETCH.
  - On ready, LOAD -> WB.
  - On ready, STORE: pc_we = 1, then FETCH if en, else IDLE.
- WB: rf_we = !rd_zero, wb_sel = (class == LOAD), pc_we = 1. Next state FETCH if en, else IDLE.
- TRAP: all strobes 0; trap and trap_cause hold until rst. en is ignored.
- Timeout counter: cleared on every entry to FETCH or MEM; saturates at MEM_TIMEOUT.
- Latency with zero-wait memory: OP/OP-IMM 4 cycles, STORE 4 cycles, LOAD 5 cycles.
- en deasserted mid-instruction: the instruction completes, then the FSM goes to IDLE.
- mem_ready outside FETCH/MEM is ignored.

Optional Feature:
- Macro: RV_CTRL_PERF_CNT_EN.
- Defined: adds outputs cyc_cnt[CNT_W] (increments every cycle busy = 1) and ret_cnt[CNT_W] (increments on each pc_we). Both reset to 0, wrap modulo 2^CNT_W, and freeze in TRAP.
- Undefined: neither port nor counter logic exists.

Decomposition:
- Package rv_ctrl_pkg:
  - state enum (IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP).
  - opcode constants OPC_LOAD, OPC_OPIMM, OPC_STORE, OPC_OP.
  - class enum.
  - trap cause constants CAUSE_ILLEGAL = 01, CAUSE_TIMEOUT = 10.
- Sub-module rv_ctrl_timeout: the saturating wait counter with clear/inc/expired.

Test Plan:
- add x3,x1,x2 (0x002081B3), ready tied to 1, en = 1 -> states FETCH, DECODE, EXEC, WB; rf_we = 1 and pc_we = 1 in cycle 4, wb_sel = 0.
- lw opcode 0000011, funct3 010, ready delayed 3 cycles in MEM -> MEM held 4 cycles with mem_req = 1, addr_sel = 1; then WB with wb_sel = 1, rf_we = 1.
- sw funct3 010 -> MEM with mem_we = 1; pc_we pulses on ready; no rf_we in any cycle.
- opcode 1111111 -> TRAP after DECODE, trap = 1, cause 01, all strobes 0 for 10 following cycles even with en = 1.
- mem_ready held 0 in FETCH -> TRAP with cause 10 after exactly MEM_TIMEOUT = 15 wait cycles; rst pulse mid-wait -> IDLE and trap = 0 immediately.
- addi x0,x0,0 (0x00000013) -> WB with rf_we = 0, pc_we = 1; en = 0 at retire -> IDLE, busy = 0.

Source files
------------

// File: rtl/rv_ctrl_pkg.sv
// Shared definitions for the RV32I multi-cycle control FSM: state codes,
// opcodes, instruction classes, trap causes and the legality decode.
package rv_ctrl_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_MEM    = 3'd4;
  localparam logic [2:0] ST_WB     = 3'd5;
  localparam logic [2:0] ST_TRAP   = 3'd6;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_OP    = 7'b0110011;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  typedef enum logic [1:0] {
    CLS_LOAD  = 2'd0,
    CLS_OPIMM = 2'd1,
    CLS_STORE = 2'd2,
    CLS_OP    = 2'd3
  } cls_t;

  // Loads allow byte/half/word and their unsigned variants; stores only b/h/w.
  function automatic logic is_legal(input logic [6:0] opcode, input logic [2:0] funct3);
    case (opcode)
      OPC_LOAD:          is_legal = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
      OPC_OPIMM, OPC_OP: is_legal = 1'b1;
      OPC_STORE:         is_legal = (funct3[2] == 1'b0) && (funct3[1:0] != 2'b11);
      default:           is_legal = 1'b0;
    endcase
  endfunction

  function automatic cls_t opcode_class(input logic [6:0] opcode);
    case (opcode)
      OPC_LOAD:  opcode_class = CLS_LOAD;
      OPC_OPIMM: opcode_class = CLS_OPIMM;
      OPC_STORE: opcode_class = CLS_STORE;
      default:   opcode_class = CLS_OP;
    endcase
  endfunction

endpackage

// File: rtl/rv_ctrl_timeout.sv
// Saturating memory wait counter; expired fires on the wait cycle that
// brings the count up to MEM_TIMEOUT.
module rv_ctrl_timeout #(
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_W        = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  localparam logic [TO_W-1:0] LIMIT = TO_W'(MEM_TIMEOUT);
  localparam logic [TO_W-1:0] LAST  = TO_W'(MEM_TIMEOUT - 1);

  logic [TO_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (inc && (cnt != LIMIT)) begin
      cnt <= cnt + TO_W'(1);
    end
  end

  assign expired = inc && (cnt >= LAST);

endmodule

// File: rtl/rv32i_multicycle_ctrl.sv
// Multi-cycle control FSM for the RV32I LOAD/OP-IMM/STORE/OP subset.
// Optional performance counters are enabled by defining RV_CTRL_PERF_CNT_EN.
module rv32i_multicycle_ctrl
  import rv_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_W        = 4
`ifdef RV_CTRL_PERF_CNT_EN
  , parameter int CNT_W     = 32
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             rd_zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             addr_sel,
  output logic             ir_we,
  output logic             alu_en,
  output logic             alu_src_imm,
  output logic             wb_sel,
  output logic             rf_we,
  output logic             pc_we,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic             busy
`ifdef RV_CTRL_PERF_CNT_EN
  , output logic [CNT_W-1:0] cyc_cnt
  , output logic [CNT_W-1:0] ret_cnt
`endif
);

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic [1:0] cause_nxt;
  cls_t       cls;
  logic       to_clear;
  logic       to_inc;
  logic       to_expired;
  logic       in_mem;
  logic       is_store;

  rv_ctrl_timeout #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .TO_W       (TO_W)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (to_clear),
    .inc    (to_inc),
    .expired(to_expired)
  );

  assign in_mem   = (state == ST_MEM);
  assign is_store = (cls == CLS_STORE);
  assign to_inc   = ((state == ST_FETCH) || in_mem) && !mem_ready;
  // Any state change clears the counter, which covers every entry to FETCH or MEM.
  assign to_clear = (state_nxt != state);

  always_comb begin
    state_nxt = state;
    cause_nxt = CAUSE_ILLEGAL;
    case (state)
      ST_IDLE:   if (en) state_nxt = ST_FETCH;
      ST_FETCH: begin
        if (mem_ready) begin
          state_nxt = ST_DECODE;
        end else if (to_expired) begin
          state_nxt = ST_TRAP;
          cause_nxt = CAUSE_TIMEOUT;
        end
      end
      ST_DECODE: state_nxt = is_legal(opcode, funct3) ? ST_EXEC : ST_TRAP;
      ST_EXEC:   state_nxt = ((cls == CLS_LOAD) || is_store) ? ST_MEM : ST_WB;
      ST_MEM: begin
        if (mem_ready) begin
          if (is_store) state_nxt = en ? ST_FETCH : ST_IDLE;
          else          state_nxt = ST_WB;
        end else if (to_expired) begin
          state_nxt = ST_TRAP;
          cause_nxt = CAUSE_TIMEOUT;
        end
      end
      ST_WB:     state_nxt = en ? ST_FETCH : ST_IDLE;
      ST_TRAP:   state_nxt = ST_TRAP;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      cls        <= CLS_LOAD;
      trap       <= 1'b0;
      trap_cause <= 2'b00;
    end else begin
      state <= state_nxt;
      if (state == ST_DECODE) cls <= opcode_class(opcode);
      if ((state_nxt == ST_TRAP) && (state != ST_TRAP)) begin
        trap       <= 1'b1;
        trap_cause <= cause_nxt;
      end
    end
  end

  assign mem_req     = (state == ST_FETCH) || in_mem;
  assign mem_we      = in_mem && is_store;
  assign addr_sel    = in_mem;
  assign ir_we       = (state == ST_FETCH) && mem_ready;
  assign alu_en      = (state == ST_EXEC);
  assign alu_src_imm = (state == ST_EXEC) && (cls != CLS_OP);
  assign wb_sel      = (state == ST_WB) && (cls == CLS_LOAD);
  assign rf_we       = (state == ST_WB) && !rd_zero;
  assign pc_we       = (state == ST_WB) || (in_mem && is_store && mem_ready);
  assign busy        = (state != ST_IDLE) && (state != ST_TRAP);

`ifdef RV_CTRL_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_cnt <= '0;
      ret_cnt <= '0;
    end else if (state != ST_TRAP) begin
      if (busy)  cyc_cnt <= cyc_cnt + CNT_W'(1);
      if (pc_we) ret_cnt <= ret_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_rv32i_multicycle_ctrl.sv
// Directed bench for rv32i_multicycle_ctrl: strobe vectors and status are
// compared against hand-computed values each cycle.
module tb_rv32i_multicycle_ctrl;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_OPIMM = 7'b0010011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_OP    = 7'b0110011;
  localparam logic [6:0] OP_BAD   = 7'b1111111;

  // Strobe order: mem_req mem_we addr_sel ir_we alu_en alu_src_imm wb_sel rf_we pc_we
  localparam logic [8:0] S_NONE     = 9'b000000000;
  localparam logic [8:0] S_FETCH_R  = 9'b100100000;
  localparam logic [8:0] S_FETCH_W  = 9'b100000000;
  localparam logic [8:0] S_EXEC_OP  = 9'b000010000;
  localparam logic [8:0] S_EXEC_IMM = 9'b000011000;
  localparam logic [8:0] S_MEM_LD   = 9'b101000000;
  localparam logic [8:0] S_MEM_ST_W = 9'b111000000;
  localparam logic [8:0] S_MEM_ST_R = 9'b111000001;
  localparam logic [8:0] S_WB_OP    = 9'b000000011;
  localparam logic [8:0] S_WB_LD    = 9'b000000111;
  localparam logic [8:0] S_WB_X0    = 9'b000000001;

  // Status order: busy trap trap_cause[1:0]
  localparam logic [3:0] T_IDLE  = 4'b0000;
  localparam logic [3:0] T_BUSY  = 4'b1000;
  localparam logic [3:0] T_ILL   = 4'b0101;
  localparam logic [3:0] T_TOUT  = 4'b0110;

  logic       clk;
  logic       rst;
  logic       en;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       rd_zero;
  logic       mem_ready;
  logic       mem_req, mem_we, addr_sel, ir_we, alu_en, alu_src_imm;
  logic       wb_sel, rf_we, pc_we, trap, busy;
  logic [1:0] trap_cause;
`ifdef RV_CTRL_PERF_CNT_EN
  logic [31:0] cyc_cnt;
  logic [31:0] ret_cnt;
`endif

  int nChecks = 0;
  int nFails  = 0;

  rv32i_multicycle_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .opcode     (opcode),
    .funct3     (funct3),
    .rd_zero    (rd_zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .addr_sel   (addr_sel),
    .ir_we      (ir_we),
    .alu_en     (alu_en),
    .alu_src_imm(alu_src_imm),
    .wb_sel     (wb_sel),
    .rf_we      (rf_we),
    .pc_we      (pc_we),
    .trap       (trap),
    .trap_cause (trap_cause),
    .busy       (busy)
`ifdef RV_CTRL_PERF_CNT_EN
    , .cyc_cnt  (cyc_cnt)
    , .ret_cnt  (ret_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic expectState(input string tag, input logic [8:0] strb, input logic [3:0] stat);
    checkOutput({tag, ".strobes"},
                {23'd0, mem_req, mem_we, addr_sel, ir_we, alu_en, alu_src_imm, wb_sel, rf_we, pc_we},
                {23'd0, strb});
    checkOutput({tag, ".status"}, {28'd0, busy, trap, trap_cause}, {28'd0, stat});
  endtask

  task automatic applyStimulus(input logic e, input logic [6:0] op, input logic [2:0] f3,
                               input logic rz, input logic rdy);
    en = e; opcode = op; funct3 = f3; rd_zero = rz; mem_ready = rdy;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(1'b0, 7'd0, 3'd0, 1'b0, 1'b0);
    expectState("reset", S_NONE, T_IDLE);
    tick();
    rst = 1'b0;
  endtask

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic       legal;
    logic [8:0] exec;
  } dec_vec_t;

  dec_vec_t decTab[6];

  initial begin
    decTab[0] = '{OP_LOAD,  3'b101, 1'b1, S_EXEC_IMM};
    decTab[1] = '{OP_LOAD,  3'b011, 1'b0, S_NONE};
    decTab[2] = '{OP_LOAD,  3'b110, 1'b0, S_NONE};
    decTab[3] = '{OP_STORE, 3'b011, 1'b0, S_NONE};
    decTab[4] = '{OP_OP,    3'b111, 1'b1, S_EXEC_OP};
    decTab[5] = '{OP_OPIMM, 3'b101, 1'b1, S_EXEC_IMM};

    rst = 1'b1;
    en = 1'b0; opcode = 7'd0; funct3 = 3'd0; rd_zero = 1'b0; mem_ready = 1'b0;
    #1;
    expectState("por", S_NONE, T_IDLE);
    tick();
    tick();
    rst = 1'b0;
    tick();
    expectState("idle", S_NONE, T_IDLE);

    // add x3,x1,x2 with zero-wait memory
    applyStimulus(1'b1, OP_OP, 3'b000, 1'b0, 1'b1);
    tick(); expectState("add.fetch", S_FETCH_R, T_BUSY);
    tick(); expectState("add.decode", S_NONE, T_BUSY);
    tick(); expectState("add.exec", S_EXEC_OP, T_BUSY);
    tick(); expectState("add.wb", S_WB_OP, T_BUSY);

    // lw with three wait cycles in MEM
    applyStimulus(1'b1, OP_LOAD, 3'b010, 1'b0, 1'b1);
    tick(); expectState("lw.fetch", S_FETCH_R, T_BUSY);
    tick(); expectState("lw.decode", S_NONE, T_BUSY);
    applyStimulus(1'b1, OP_LOAD, 3'b010, 1'b0, 1'b0);
    tick(); expectState("lw.exec", S_EXEC_IMM, T_BUSY);
    for (int i = 0; i < 3; i++) begin
      tick(); expectState($sformatf("lw.memwait%0d", i), S_MEM_LD, T_BUSY);
    end
    tick();
    applyStimulus(1'b1, OP_LOAD, 3'b010, 1'b0, 1'b1);
    expectState("lw.memready", S_MEM_LD, T_BUSY);
    tick(); expectState("lw.wb", S_WB_LD, T_BUSY);

    // sw, one wait cycle, en dropped while the store completes
    applyStimulus(1'b1, OP_STORE, 3'b010, 1'b0, 1'b1);
    tick(); expectState("sw.fetch", S_FETCH_R, T_BUSY);
    tick(); expectState("sw.decode", S_NONE, T_BUSY);
    applyStimulus(1'b1, OP_STORE, 3'b010, 1'b0, 1'b0);
    tick(); expectState("sw.exec", S_EXEC_IMM, T_BUSY);
    tick(); expectState("sw.memwait", S_MEM_ST_W, T_BUSY);
    applyStimulus(1'b0, OP_STORE, 3'b010, 1'b0, 1'b1);
    expectState("sw.memready", S_MEM_ST_R, T_BUSY);
    tick(); expectState("sw.idle", S_NONE, T_IDLE);
    tick(); expectState("sw.idle2", S_NONE, T_IDLE);

    // addi x0,x0,0 then retire into IDLE
    applyStimulus(1'b1, OP_OPIMM, 3'b000, 1'b1, 1'b1);
    tick(); expectState("addi.fetch", S_FETCH_R, T_BUSY);
    tick(); expectState("addi.decode", S_NONE, T_BUSY);
    tick(); expectState("addi.exec", S_EXEC_IMM, T_BUSY);
    tick(); expectState("addi.wb", S_WB_X0, T_BUSY);
    applyStimulus(1'b0, OP_OPIMM, 3'b000, 1'b1, 1'b1);
    tick(); expectState("addi.idle", S_NONE, T_IDLE);

    // illegal opcode traps and stays put regardless of en/ready
    applyStimulus(1'b1, OP_BAD, 3'b000, 1'b0, 1'b1);
    tick(); expectState("ill.fetch", S_FETCH_R, T_BUSY);
    tick(); expectState("ill.decode", S_NONE, T_BUSY);
    tick(); expectState("ill.trap", S_NONE, T_ILL);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, OP_OP, 3'b000, 1'b0, i[0]);
      tick(); expectState($sformatf("ill.hold%0d", i), S_NONE, T_ILL);
    end
    doReset();

    // funct3 legality boundaries
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b1, decTab[k].op, decTab[k].f3, 1'b0, 1'b1);
      tick(); tick();
      tick();
      expectState($sformatf("dec%0d", k), decTab[k].exec, decTab[k].legal ? T_BUSY : T_ILL);
      doReset();
    end

    // fetch timeout after exactly 15 wait cycles
    applyStimulus(1'b1, OP_OP, 3'b000, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 15; i++) begin
      expectState($sformatf("tout.wait%0d", i), S_FETCH_W, T_BUSY);
      tick();
    end
    expectState("tout.trap", S_NONE, T_TOUT);
    tick(); expectState("tout.hold", S_NONE, T_TOUT);
    rst = 1'b1;
    #1;
    expectState("tout.rst", S_NONE, T_IDLE);
    tick();
    rst = 1'b0;

    // reset pulse in the middle of a fetch wait
    applyStimulus(1'b1, OP_OP, 3'b000, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 5; i++) begin
      expectState($sformatf("mid.wait%0d", i), S_FETCH_W, T_BUSY);
      tick();
    end
    #1;
    rst = 1'b1;
    #1;
    expectState("mid.rst", S_NONE, T_IDLE);
    #1;
    rst = 1'b0;
    applyStimulus(1'b1, OP_OP, 3'b000, 1'b0, 1'b1);
    tick(); expectState("mid.refetch", S_FETCH_R, T_BUSY);
    tick(); expectState("mid.decode", S_NONE, T_BUSY);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
